alu_seq: RTL and testbench

- Parametrised, handshaked successor to the single-cycle ALU.
- Adds XOR, signed/unsigned compare and shifts to the existing ops, plus iterative unsigned multiply and divide/remainder (RV32M-style).
- Sits in the execute stage; the pipeline stalls on in_ready/out_valid while a multi-cycle op runs.
- One operation in flight at a time; result and zero flag are registered.

---
 rtl/alu_seq.sv | 192 +++++++++++++++++++
 tb/tb_alu_seq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: handshaked execute-stage ALU with single-cycle logic/arith/shift
// ops and iterative unsigned multiply (shift-add) and divide (restoring).
// One operation in flight; result and zero flag are registered.
// Optional build macro ALU_DIV0_FAST_EN: DIVU/REMU by zero skip the
// iterative loop and complete with latency 1 (same results either way).
module alu_seq #(
  parameter int WIDTH   = 32,
  parameter int CONTROL = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CONTROL-1:0] alu_control,
  input  logic [WIDTH-1:0]   operand_a,
  input  logic [WIDTH-1:0]   operand_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero_flag
);

  localparam int ShiftW = $clog2(WIDTH);
  localparam int CountW = $clog2(WIDTH + 1);

  localparam logic [CONTROL-1:0] OP_ADD   = CONTROL'(0);
  localparam logic [CONTROL-1:0] OP_SUB   = CONTROL'(1);
  localparam logic [CONTROL-1:0] OP_AND   = CONTROL'(2);
  localparam logic [CONTROL-1:0] OP_OR    = CONTROL'(3);
  localparam logic [CONTROL-1:0] OP_XOR   = CONTROL'(4);
  localparam logic [CONTROL-1:0] OP_SLT   = CONTROL'(5);
  localparam logic [CONTROL-1:0] OP_SLTU  = CONTROL'(6);
  localparam logic [CONTROL-1:0] OP_SLL   = CONTROL'(7);
  localparam logic [CONTROL-1:0] OP_SRL   = CONTROL'(8);
  localparam logic [CONTROL-1:0] OP_SRA   = CONTROL'(9);
  localparam logic [CONTROL-1:0] OP_MUL   = CONTROL'(10);
  localparam logic [CONTROL-1:0] OP_MULHU = CONTROL'(11);
  localparam logic [CONTROL-1:0] OP_DIVU  = CONTROL'(12);
  localparam logic [CONTROL-1:0] OP_REMU  = CONTROL'(13);

`ifdef ALU_DIV0_FAST_EN
  localparam bit FastDiv0 = 1'b1;
`else
  localparam bit FastDiv0 = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} aluState_e;

  aluState_e          state_q;
  logic [CONTROL-1:0] opCode_q;
  logic [WIDTH-1:0]   opA_q;
  logic [WIDTH-1:0]   opB_q;
  logic [WIDTH-1:0]   accHi_q;
  logic [WIDTH-1:0]   accLo_q;
  logic [CountW-1:0]  count_q;
  logic [WIDTH-1:0]   result_q;
  logic               zero_q;
  logic               outValid_q;
  logic               inReady_q;

  logic [WIDTH-1:0]   aluResult;
  logic [ShiftW-1:0]  shamt;
  logic               isMulIn;
  logic               isDivIn;
  logic [WIDTH-1:0]   div0Result;

  logic [WIDTH:0]     mulSum;
  logic [WIDTH:0]     divShift;
  logic               divGe;
  logic [WIDTH-1:0]   divSub;
  logic [WIDTH-1:0]   accHi_d;
  logic [WIDTH-1:0]   accLo_d;
  logic [WIDTH-1:0]   multiResult_d;

  // Single-cycle datapath, evaluated straight from the presented operands
  // so the result can be registered on the accept edge.
  always_comb begin
    aluResult  = '0;
    shamt      = operand_b[ShiftW-1:0];
    isMulIn    = (alu_control == OP_MUL) || (alu_control == OP_MULHU);
    isDivIn    = (alu_control == OP_DIVU) || (alu_control == OP_REMU);
    div0Result = (alu_control == OP_DIVU) ? '1 : operand_a;
    case (alu_control)
      OP_ADD:  aluResult = operand_a + operand_b;
      OP_SUB:  aluResult = operand_a - operand_b;
      OP_AND:  aluResult = operand_a & operand_b;
      OP_OR:   aluResult = operand_a | operand_b;
      OP_XOR:  aluResult = operand_a ^ operand_b;
      OP_SLT:  aluResult = {{(WIDTH-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
      OP_SLTU: aluResult = {{(WIDTH-1){1'b0}}, (operand_a < operand_b)};
      OP_SLL:  aluResult = operand_a << shamt;
      OP_SRL:  aluResult = operand_a >> shamt;
      OP_SRA:  aluResult = $signed(operand_a) >>> shamt;
      default: aluResult = '0;
    endcase
  end

  // One iteration of the multi-cycle engine. Multiply keeps {product high,
  // multiplier/product low} in accHi/accLo and shifts right each step;
  // divide keeps {remainder, quotient} and shifts left, restoring on borrow.
  always_comb begin
    mulSum   = {1'b0, accHi_q} + (accLo_q[0] ? {1'b0, opA_q} : '0);
    divShift = {accHi_q, accLo_q[WIDTH-1]};
    divGe    = (divShift >= {1'b0, opB_q});
    divSub   = divShift[WIDTH-1:0] - opB_q;
    if ((opCode_q == OP_MUL) || (opCode_q == OP_MULHU)) begin
      accHi_d = mulSum[WIDTH:1];
      accLo_d = {mulSum[0], accLo_q[WIDTH-1:1]};
    end else begin
      accHi_d = divGe ? divSub : divShift[WIDTH-1:0];
      accLo_d = {accLo_q[WIDTH-2:0], divGe};
    end
    if ((opCode_q == OP_MUL) || (opCode_q == OP_DIVU)) begin
      multiResult_d = accLo_d;
    end else begin
      multiResult_d = accHi_d;
    end
  end

  // Control FSM with registered handshake outputs, result and zero flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      opCode_q   <= '0;
      opA_q      <= '0;
      opB_q      <= '0;
      accHi_q    <= '0;
      accLo_q    <= '0;
      count_q    <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            opCode_q  <= alu_control;
            opA_q     <= operand_a;
            opB_q     <= operand_b;
            inReady_q <= 1'b0;
            if (FastDiv0 && isDivIn && (operand_b == '0)) begin
              state_q    <= DONE;
              result_q   <= div0Result;
              zero_q     <= (div0Result == '0);
              outValid_q <= 1'b1;
            end else if (isMulIn || isDivIn) begin
              state_q <= BUSY;
              count_q <= CountW'(WIDTH);
              accHi_q <= '0;
              accLo_q <= isMulIn ? operand_b : operand_a;
            end else begin
              state_q    <= DONE;
              result_q   <= aluResult;
              zero_q     <= (aluResult == '0);
              outValid_q <= 1'b1;
            end
          end
        end
        BUSY: begin
          accHi_q <= accHi_d;
          accLo_q <= accLo_d;
          count_q <= count_q - 1'b1;
          if (count_q == CountW'(1)) begin
            state_q    <= DONE;
            result_q   <= multiResult_d;
            zero_q     <= (multiResult_d == '0);
            outValid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q    <= IDLE;
            outValid_q <= 1'b0;
            inReady_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = inReady_q;
  assign out_valid = outValid_q;
  assign result    = result_q;
  assign zero_flag = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: self-checking bench for alu_seq at WIDTH=32 with directed
// vectors, random ops against an arithmetic reference model, stall,
// back-to-back and mid-operation reset scenarios.
// Honours ALU_DIV0_FAST_EN for expected divide-by-zero latency.
module tb_alu_seq;

  localparam int W = 32;

`ifdef ALU_DIV0_FAST_EN
  localparam int Div0Lat = 1;
`else
  localparam int Div0Lat = W + 1;
`endif

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alu_control;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          zero_flag;

  int checks;
  int fails;

  alu_seq #(.WIDTH(W), .CONTROL(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .operand_a  (operand_a),
    .operand_b  (operand_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero_flag  (zero_flag)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain RV32-style arithmetic on the full-width values.
  function automatic logic [W-1:0] refResult(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned prod;
    int sh;
    prod = 64'(a) * 64'(b);
    sh   = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6:  return (a < b) ? 32'd1 : 32'd0;
      7:  return a << sh;
      8:  return a >> sh;
      9:  return $signed(a) >>> sh;
      10: return prod[31:0];
      11: return prod[63:32];
      12: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      13: return (b == 0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int refLatency(input int op, input logic [W-1:0] b);
    if ((op == 12 || op == 13) && b == 0) return Div0Lat;
    if (op >= 10 && op <= 13) return W + 1;
    return 1;
  endfunction

  // Drives one operation through the handshake and returns what was observed.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               output logic [W-1:0] res, output logic zf, output int lat,
                               output bit busyReadyLow, output bit timedOut);
    int guard;
    timedOut = 0;
    busyReadyLow = 1;
    lat = 1;
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) timedOut = 1;
    in_valid    = 1'b1;
    alu_control = op;
    operand_a   = a;
    operand_b   = b;
    @(posedge clk);
    @(negedge clk);
    in_valid    = 1'b0;
    alu_control = 4'($urandom);
    operand_a   = $urandom;
    operand_b   = $urandom;
    guard = 0;
    while (out_valid !== 1'b1 && guard < 100) begin
      if (in_ready !== 1'b0) busyReadyLow = 0;
      @(negedge clk);
      lat++;
      guard++;
    end
    if (guard >= 100) timedOut = 1;
    res = result;
    zf  = zero_flag;
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== '0) begin fails++; $display("[TB] FAIL reset_result got=%h want=0", result); end
    checks++; if (zero_flag !== 1'b0) begin fails++; $display("[TB] FAIL reset_zero got=%b want=0", zero_flag); end
    rst = 1'b0;
  endtask

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    int           lat;
  } vec_t;

  task automatic test_directed();
    vec_t v[11];
    logic [W-1:0] res;
    logic zf;
    int lat;
    bit busyLow, tmo;
    v[0]  = '{4'd0,  32'h7FFF_FFFF, 32'd1,          32'h8000_0000, 1};
    v[1]  = '{4'd1,  32'd5,         32'd5,          32'd0,         1};
    v[2]  = '{4'd5,  32'hFFFF_FFFF, 32'd1,          32'd1,         1};
    v[3]  = '{4'd6,  32'hFFFF_FFFF, 32'd1,          32'd0,         1};
    v[4]  = '{4'd9,  32'h8000_0000, 32'h24,         32'hF800_0000, 1};
    v[5]  = '{4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'h0000_0001, 33};
    v[6]  = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 33};
    v[7]  = '{4'd12, 32'd100,       32'd7,          32'd14,        33};
    v[8]  = '{4'd13, 32'd100,       32'd7,          32'd2,         33};
    v[9]  = '{4'd12, 32'd9,         32'd0,          32'hFFFF_FFFF, Div0Lat};
    v[10] = '{4'd13, 32'd9,         32'd0,          32'd9,         Div0Lat};
    for (int i = 0; i < 11; i++) begin
      applyStimulus(v[i].op, v[i].a, v[i].b, res, zf, lat, busyLow, tmo);
      checks++; if (tmo) begin fails++; $display("[TB] FAIL dir%0d_timeout got=1 want=0", i); end
      checks++; if (res !== v[i].exp) begin fails++; $display("[TB] FAIL dir%0d_result got=%h want=%h", i, res, v[i].exp); end
      checks++; if (zf !== (v[i].exp == 0)) begin fails++; $display("[TB] FAIL dir%0d_zero got=%b want=%b", i, zf, (v[i].exp == 0)); end
      checks++; if (lat != v[i].lat) begin fails++; $display("[TB] FAIL dir%0d_latency got=%0d want=%0d", i, lat, v[i].lat); end
      checks++; if (!busyLow) begin fails++; $display("[TB] FAIL dir%0d_busy_in_ready got=1 want=0", i); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, exp;
    logic [3:0] op;
    logic zf;
    int lat, mode;
    bit busyLow, tmo;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(0, 15));
      mode = $urandom_range(0, 3);
      a = (mode == 3) ? 32'hFFFF_FFFF : $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        default: b = $urandom;
      endcase
      exp = refResult(int'(op), a, b);
      applyStimulus(op, a, b, res, zf, lat, busyLow, tmo);
      checks++; if (tmo || res !== exp) begin fails++; $display("[TB] FAIL rnd%0d_op%0d_result got=%h want=%h", i, op, res, exp); end
      checks++; if (zf !== (exp == 0)) begin fails++; $display("[TB] FAIL rnd%0d_op%0d_zero got=%b want=%b", i, op, zf, (exp == 0)); end
      checks++; if (lat != refLatency(int'(op), b)) begin fails++; $display("[TB] FAIL rnd%0d_op%0d_latency got=%0d want=%0d", i, op, lat, refLatency(int'(op), b)); end
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    alu_control = 4'd4;
    operand_a   = 32'h0000_A5A5;
    operand_b   = 32'h0000_5A5A;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin fails++; $display("[TB] FAIL stall_first_valid got=%b want=1", out_valid); end
    for (int i = 0; i < 5; i++) begin
      in_valid    = i[0] ? 1'b0 : 1'b1;
      alu_control = 4'd1;
      operand_a   = 32'd3;
      operand_b   = 32'd3;
      @(negedge clk);
      checks++; if (result !== 32'h0000_FFFF) begin fails++; $display("[TB] FAIL stall%0d_result got=%h want=0000ffff", i, result); end
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin fails++; $display("[TB] FAIL stall%0d_handshake got=%b%b want=10", i, out_valid, in_ready); end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL stall_release_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL stall_release_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== 32'h0000_FFFF || zero_flag !== 1'b0) begin fails++; $display("[TB] FAIL stall_hold_after_handoff got=%h/%b want=0000ffff/0", result, zero_flag); end
  endtask

  task automatic test_back_to_back();
    int pulses;
    pulses = 0;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 4'd0;
    operand_a   = 32'd40;
    operand_b   = 32'd2;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    checks++; if (pulses != 5) begin fails++; $display("[TB] FAIL b2b_throughput got=%0d want=5", pulses); end
    checks++; if (result !== 32'd42) begin fails++; $display("[TB] FAIL b2b_result got=%h want=0000002a", result); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    logic zf;
    int lat;
    bit busyLow, tmo, sawValid;
    @(negedge clk);
    in_valid    = 1'b1;
    alu_control = 4'd12;
    operand_a   = 32'd100;
    operand_b   = 32'd7;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_busy got=%b%b want=00", in_ready, out_valid); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL midrst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (result !== '0) begin fails++; $display("[TB] FAIL midrst_result got=%h want=0", result); end
    sawValid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) sawValid = 1;
    end
    checks++; if (sawValid) begin fails++; $display("[TB] FAIL midrst_aborted got=1 want=0"); end
    applyStimulus(4'd0, 32'd2, 32'd3, res, zf, lat, busyLow, tmo);
    checks++; if (tmo || res !== 32'd5) begin fails++; $display("[TB] FAIL midrst_add got=%h want=00000005", res); end
    checks++; if (lat != 1) begin fails++; $display("[TB] FAIL midrst_add_latency got=%0d want=1", lat); end
  endtask

  // Test sequence.
  initial begin
    checks      = 0;
    fails       = 0;
    rst         = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    alu_control = '0;
    operand_a   = '0;
    operand_b   = '0;
    test_reset();
    test_directed();
    test_random();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
